seq_multiplier_shift_add: RTL

Parametrised, multi-cycle shift-and-add multiplier. It is the sequential successor to the team's 2-bit gate-level combinational multiplier. It takes WIDTH-bit operands on a start pulse and iterates one partial product per clock. It presents a 2*WIDTH-bit product with a one-cycle done pulse. An optional two's-complement mode is included. It serves as the area-cheap multiply unit for datapaths that can tolerate WIDTH+1 cycles of latency.

---
 rtl/seq_multiplier_shift_add.sv | 126 ++++++++++++
 1 files changed

// File: rtl/seq_multiplier_shift_add.sv
// Multi-cycle shift-and-add multiplier: one partial product per clock, WIDTH+1 cycle latency.
// Optional two's-complement mode multiplies magnitudes and applies the sign at the end.
module seq_multiplier_shift_add #(
  parameter int WIDTH  = 4,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [2*WIDTH:0]    acc_q, acc_d;
  logic [CW-1:0]       count_q, count_d;
  logic                neg_q, neg_d;
  logic [2*WIDTH-1:0]  product_q, product_d;
  logic                done_q, done_d;

  logic [WIDTH-1:0]    mag1, mag2;
  logic                sign_in;
  logic [WIDTH:0]      partial;

  // The most-negative operand negates to itself, which read as unsigned is its magnitude.
  always_comb begin
    mag1    = num1;
    mag2    = num2;
    sign_in = 1'b0;
    if (SIGNED != 0) begin
      mag1    = num1[WIDTH-1] ? (~num1 + ONE_W) : num1;
      mag2    = num2[WIDTH-1] ? (~num2 + ONE_W) : num2;
      sign_in = num1[WIDTH-1] ^ num2[WIDTH-1];
    end
  end

  // Upper WIDTH+1 bits hold the running sum; its top bit is always clear before the add.
  always_comb begin
    partial = acc_q[2*WIDTH:WIDTH] + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = mag1;
          mplier_d = mag2;
          neg_d    = sign_in;
          acc_d    = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end

      RUN: begin
        acc_d    = {1'b0, partial, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        product_d = neg_q ? (~acc_q[2*WIDTH-1:0] + ONE_P) : acc_q[2*WIDTH-1:0];
        done_d    = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign product = product_q;

endmodule
